// File: rtl/div_unit_pkg.sv
// Shared RV32M divider types: operation encoding, FSM states and iteration count.
package riscv_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_t;

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_unit_if.sv
// Issue/writeback bundle between the execute stage and the divide unit.
interface div_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  import riscv_pkg::*;

  logic                  start;
  div_op_t               op;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic [4:0]            rd_in;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [4:0]            rd_out;

  modport master (
    output start, op, src_a, src_b, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, src_a, src_b, rd_in, flush,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left and trial-subtract the divisor.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  logic [DATA_WIDTH:0] sh_rem;
  logic [DATA_WIDTH:0] trial;
  logic                fits;

  // When the shifted-out top bit is set the partial remainder always exceeds
  // the divisor, and the low bits of the difference are still exact mod 2^W.
  always_comb begin
    sh_rem   = {rem, quo[DATA_WIDTH-1]};
    trial    = {1'b0, sh_rem[DATA_WIDTH-1:0]} - {1'b0, divisor};
    fits     = sh_rem[DATA_WIDTH] | ~trial[DATA_WIDTH];
    rem_next = fits ? trial[DATA_WIDTH-1:0] : sh_rem[DATA_WIDTH-1:0];
    quo_next = {quo[DATA_WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per cycle.
//   state  | meaning
//   S_IDLE | waiting for start; special cases resolve here straight to S_DONE
//   S_CALC | 32 shift/trial-subtract iterations on magnitudes
//   S_FIX  | select quotient/remainder, apply sign, register result
//   S_DONE | done pulse, result and rd_out valid
module div_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  div_unit_if.slave bus
);

  div_state_t            state, state_nxt;
  logic [4:0]            cnt;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, div_q;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;
  logic [DATA_WIDTH-1:0] result_q;
  logic [4:0]            rd_q, rd_out_q;
  div_op_t               op_q;
  logic                  neg_q, neg_r;

  logic                  is_signed, sign_a, sign_b, b_zero, ovf, special, accept;
  logic [DATA_WIDTH-1:0] mag_a, mag_b, special_val, fix_sel, fix_val;

  always_comb begin
    is_signed = ~bus.op[0];
    sign_a    = is_signed & bus.src_a[DATA_WIDTH-1];
    sign_b    = is_signed & bus.src_b[DATA_WIDTH-1];
    mag_a     = sign_a ? -bus.src_a : bus.src_a;
    mag_b     = sign_b ? -bus.src_b : bus.src_b;
    b_zero    = (bus.src_b == '0);
    ovf       = is_signed && (bus.src_a == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (bus.src_b == '1);
    special   = b_zero | ovf;
    if (b_zero)
      special_val = bus.op[1] ? bus.src_a : '1;
    else
      special_val = bus.op[1] ? '0 : bus.src_a;
    accept    = bus.start & ~bus.flush;
    fix_sel   = op_q[1] ? rem_q : quo_q;
    fix_val   = (op_q[1] ? neg_r : neg_q) ? -fix_sel : fix_sel;
  end

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
      S_CALC: if (bus.flush) state_nxt = S_IDLE;
              else if (cnt == '0) state_nxt = S_FIX;
      S_FIX:  state_nxt = bus.flush ? S_IDLE : S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      op_q     <= DIV;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q  <= bus.op;
          rd_q  <= bus.rd_in;
          rem_q <= '0;
          quo_q <= mag_a;
          div_q <= mag_b;
          cnt   <= 5'(DIV_ITERS - 1);
          neg_q <= sign_a ^ sign_b;
          neg_r <= sign_a;
          if (special) begin
            result_q <= special_val;
            rd_out_q <= bus.rd_in;
          end
        end
        S_CALC: if (!bus.flush) begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (cnt != '0) cnt <= cnt - 5'd1;
        end
        S_FIX: if (!bus.flush) begin
          result_q <= fix_val;
          rd_out_q <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == S_CALC) || (state == S_FIX);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: table of operations plus flush/reset sequences.
module tb_div_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_unit_if #(.DATA_WIDTH(32)) bus ();

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          exp_k;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one op at a negedge; k counts edges after the start edge until done is seen.
  task automatic run_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int k, output logic saw_busy,
                        output logic done_low_after);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.rd_in = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    saw_busy = 1'b0;
    while (!bus.done && k < 100) begin
      saw_busy |= bus.busy;
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    done_low_after = ~bus.done;
  endtask

  int          k;
  logic        sb, dl;
  logic [31:0] held;

  initial begin
    vecs[0]  = '{DIV,  32'd100,        32'd7,          5'd5,  32'd14,         33};
    vecs[1]  = '{REM,  32'd100,        32'd7,          5'd6,  32'd2,          33};
    vecs[2]  = '{DIV,  32'hFFFFFF9C,   32'd7,          5'd7,  32'hFFFFFFF2,   33};
    vecs[3]  = '{REM,  32'hFFFFFF9C,   32'd7,          5'd8,  32'hFFFFFFFE,   33};
    vecs[4]  = '{DIVU, 32'hFFFFFFFF,   32'd2,          5'd9,  32'h7FFFFFFF,   33};
    vecs[5]  = '{DIV,  32'h00001234,   32'd0,          5'd10, 32'hFFFFFFFF,   0};
    vecs[6]  = '{DIVU, 32'h00001234,   32'd0,          5'd11, 32'hFFFFFFFF,   0};
    vecs[7]  = '{REM,  32'h00001234,   32'd0,          5'd12, 32'h00001234,   0};
    vecs[8]  = '{REMU, 32'h00001234,   32'd0,          5'd13, 32'h00001234,   0};
    vecs[9]  = '{DIV,  32'h80000000,   32'hFFFFFFFF,   5'd14, 32'h80000000,   0};
    vecs[10] = '{REM,  32'h80000000,   32'hFFFFFFFF,   5'd15, 32'h00000000,   0};
    vecs[11] = '{DIVU, 32'h80000000,   32'hFFFFFFFF,   5'd16, 32'h00000000,   33};
    vecs[12] = '{REMU, 32'h80000000,   32'hFFFFFFFF,   5'd17, 32'h80000000,   33};
    vecs[13] = '{DIV,  32'd100,        32'hFFFFFFF9,   5'd18, 32'hFFFFFFF2,   33};
    vecs[14] = '{REM,  32'd100,        32'hFFFFFFF9,   5'd19, 32'd2,          33};
    vecs[15] = '{DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   5'd20, 32'd14,         33};
    vecs[16] = '{DIV,  32'h80000000,   32'd2,          5'd31, 32'hC0000000,   33};

    bus.start = 1'b0; bus.op = DIV; bus.src_a = '0; bus.src_b = '0;
    bus.rd_in = '0; bus.flush = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset_busy",   {31'b0, bus.busy}, 32'd0);
    check("reset_done",   {31'b0, bus.done}, 32'd0);
    check("reset_result", bus.result,        32'd0);
    check("reset_rd_out", {27'b0, bus.rd_out}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, k, sb, dl);
      check($sformatf("v%0d_result", i), bus.result, vecs[i].exp);
      check($sformatf("v%0d_rd_out", i), {27'b0, bus.rd_out}, {27'b0, vecs[i].rd});
      check($sformatf("v%0d_latency", i), k, vecs[i].exp_k);
      check($sformatf("v%0d_busy_seen", i), {31'b0, sb}, {31'b0, (vecs[i].exp_k != 0)});
      check($sformatf("v%0d_done_pulse", i), {31'b0, dl}, 32'd1);
    end

    // flush together with start in IDLE: nothing starts
    held = bus.result;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = DIV; bus.src_a = 32'd9; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_start_done", {31'b0, bus.done}, 32'd0);

    // flush at cycle 10 of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIV; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.rd_in = 5'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_flush_busy", {31'b0, bus.busy}, 32'd1);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy",   {31'b0, bus.busy}, 32'd0);
    check("flush_done",   {31'b0, bus.done}, 32'd0);
    check("flush_result", bus.result, held);
    @(posedge clk); #1;
    check("flush_done_next", {31'b0, bus.done}, 32'd0);
    run_op(DIVU, 32'd1000, 32'd10, 5'd4, k, sb, dl);
    check("after_flush_result",  bus.result, 32'd100);
    check("after_flush_latency", k, 33);
    check("after_flush_rd_out",  {27'b0, bus.rd_out}, 32'd4);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.op = REMU; bus.src_a = 32'd77; bus.src_b = 32'd5; bus.rd_in = 5'd22;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_busy",   {31'b0, bus.busy}, 32'd0);
    check("rst_mid_done",   {31'b0, bus.done}, 32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    check("rst_mid_rd_out", {27'b0, bus.rd_out}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_done", {31'b0, bus.done}, 32'd0);
    run_op(DIV, 32'd100, 32'd7, 5'd5, k, sb, dl);
    check("after_rst_result",  bus.result, 32'd14);
    check("after_rst_latency", k, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
